local_port_buffer: RTL

LOCAL_PORT_BUFFER -- requirements
Module: local_port_buffer

---
 rtl/noc_pkg.sv | 12 +
 rtl/port_fifo_ram.sv | 25 ++
 rtl/local_port_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width and output-handshake state encoding
// used by injectors, routers and local port buffers.
package noc_pkg;

  localparam int PACKETWIDTH = 56;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_REQ  = 1'b1
  } out_state_e;

endpackage

// File: rtl/port_fifo_ram.sv
// DEPTH x PACKETWIDTH packet storage: synchronous write, asynchronous read.
module port_fifo_ram
  import noc_pkg::*;
#(
  parameter int PACKETWIDTH = noc_pkg::PACKETWIDTH,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [PACKETWIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [PACKETWIDTH-1:0] rd_data
);

  logic [PACKETWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/local_port_buffer.sv
// Local-port packet FIFO between an injector (req/grant in) and the router
// arbiter (req/grant out), with an accepted-packet counter.
module local_port_buffer
  import noc_pkg::*;
#(
  parameter int PACKETWIDTH = noc_pkg::PACKETWIDTH,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqUpStr,
  input  logic [PACKETWIDTH-1:0] PacketIn,
  output logic                   GntUpStr,
  output logic                   UpStrFull,
  output logic                   ReqDnStr,
  input  logic                   GntDnStr,
  output logic [PACKETWIDTH-1:0] PacketOut,
  output logic [15:0]            PktCount
);

  localparam int CNT_W = ADDR_W + 1;

  logic              gnt_up_q, gnt_up_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  out_state_e        state_q;
  logic              req_dn_q;

  logic full;
  logic push;
  logic pop;

  // The grant cycle masks the injector's still-high request.
  assign full = (count_q == CNT_W'(DEPTH));
  assign push = ReqUpStr & ~gnt_up_q & ~full;
  assign pop  = (state_q == OUT_REQ) & GntDnStr;

  always_comb begin
    gnt_up_d    = push;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    if (push) begin
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      pkt_count_d = pkt_count_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_up_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      gnt_up_q    <= gnt_up_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Returning to OUT_IDLE after each pop guarantees a low cycle on ReqDnStr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= OUT_IDLE;
      req_dn_q <= 1'b0;
    end else begin
      case (state_q)
        OUT_IDLE: if (count_q != '0) begin
          req_dn_q <= 1'b1;
          state_q  <= OUT_REQ;
        end
        OUT_REQ: if (GntDnStr) begin
          req_dn_q <= 1'b0;
          state_q  <= OUT_IDLE;
        end
      endcase
    end
  end

  port_fifo_ram #(
    .PACKETWIDTH(PACKETWIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data(PacketIn),
    .rd_addr(rd_ptr_q),
    .rd_data(PacketOut)
  );

  assign GntUpStr  = gnt_up_q;
  assign UpStrFull = full;
  assign ReqDnStr  = req_dn_q;
  assign PktCount  = pkt_count_q;

endmodule
